enemy_shot: RTL and testbench

Enemy-side projectile engine; the downward counterpart of the player's upward shot (municao1). After a cooldown it picks a pseudo-random live enemy, spawns one shot below it, and moves the shot down once per frame. It detects hits on the player ship and drives R/G/B for the top-level pixel OR-mix.

---
 rtl/si_pkg.sv | 38 +++
 rtl/rect_overlap.sv | 29 ++
 rtl/enemy_shot.sv | 202 ++++++++++++++++++++
 tb/tb_enemy_shot.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/si_pkg.sv
// Shared space-invaders constants: screen and ship geometry, enemy grid size,
// shot geometry/colour and the enemy-shot FSM state encoding.
package si_pkg;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int SHIP_Y     = 440;
  localparam int SHIP_W     = 40;
  localparam int SHIP_H     = 20;
  localparam int N_ENEMY    = 24;
  localparam int ENEMY_H    = 30;
  localparam int SHOT_W     = 4;
  localparam int SHOT_H     = 12;
  localparam int SPEED      = 4;
  localparam int COOLDOWN   = 60;
  localparam int SHOT_X_OFS = 8;

  localparam logic [7:0] SHOT_R = 8'hFF;
  localparam logic [7:0] SHOT_G = 8'h40;
  localparam logic [7:0] SHOT_B = 8'h00;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    WAIT   = 3'd2,
    CHECK  = 3'd3,
    FLY    = 3'd4,
    HIT    = 3'd5
  } state_t;

  // Unsigned 11-bit add that clamps at 2047 instead of wrapping.
  function automatic logic [10:0] sat_add11(input logic [10:0] a, input logic [10:0] b);
    logic [11:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[11] ? 11'h7FF : s[10:0];
  endfunction

endpackage

// File: rtl/rect_overlap.sv
// Combinational axis-aligned bounding-box overlap test of rectangles a and b.
// Edges are half-open: a rectangle covers [x, x+w) by [y, y+h).
module rect_overlap #(
  parameter int W = 11
) (
  input  logic [W-1:0] a_x,
  input  logic [W-1:0] a_y,
  input  logic [W-1:0] a_w,
  input  logic [W-1:0] a_h,
  input  logic [W-1:0] b_x,
  input  logic [W-1:0] b_y,
  input  logic [W-1:0] b_w,
  input  logic [W-1:0] b_h,
  output logic         overlap
);

  logic [W:0] a_r, a_b, b_r, b_b;

  always_comb begin
    // One extra bit keeps the far edges from wrapping near the top of the range.
    a_r = {1'b0, a_x} + {1'b0, a_w};
    a_b = {1'b0, a_y} + {1'b0, a_h};
    b_r = {1'b0, b_x} + {1'b0, b_w};
    b_b = {1'b0, b_y} + {1'b0, b_h};
    overlap = (a_r > {1'b0, b_x}) && ({1'b0, a_x} < b_r) &&
              (a_b > {1'b0, b_y}) && ({1'b0, a_y} < b_b);
  end

endmodule

// File: rtl/enemy_shot.sv
// Enemy projectile engine: cooldown, pseudo-random live-enemy pick, downward
// flight, ship hit detection and shot pixel colour. Build option: ENEMY_SHOT_ACCEL_EN.
module enemy_shot
  import si_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         h_counter,
  input  logic [9:0]         v_counter,
  input  logic               frame_tick,
  input  logic               game_run,
  input  logic [31:0]        rand_val,
  input  logic [N_ENEMY-1:0] enemy_alive,
  output logic [4:0]         sel_id,
  input  logic [10:0]        sel_posX,
  input  logic [10:0]        sel_posY,
  input  logic [10:0]        posX_Nave,
  input  logic               vivo_jogador,
  output logic [10:0]        posX_Municao2,
  output logic [10:0]        posY_Municao2,
  output logic               tiro_ativo_inimigo,
  output logic               hit_jogador,
  output logic [7:0]         R,
  output logic [7:0]         G,
  output logic [7:0]         B,
  output state_t             state_dbg
);

  localparam logic [10:0] SCREEN_H_11 = 11'(SCREEN_H);
  localparam logic [10:0] ENEMY_H_11  = 11'(ENEMY_H);
  localparam logic [10:0] X_OFS_11    = 11'(SHOT_X_OFS);
  localparam logic [6:0]  COOL_7      = 7'(COOLDOWN);
  localparam logic [4:0]  N_ID        = 5'(N_ENEMY);
  localparam logic [4:0]  LAST_ID     = 5'(N_ENEMY - 1);

  state_t      state, state_n;
  logic [6:0]  cooldown, cool_n;
  logic [4:0]  sel_q, sel_n, attempts, att_n, pick;
  logic [10:0] pos_x, pos_y, x_n, y_n, step;
  logic        active, act_n, pend, pend_n;
  logic        overlap, hit_now, draw;
  logic [11:0] h12, v12, x12, y12;
  logic [7:0]  r_q, g_q, b_q;

  wire unused_rand = ^rand_val[31:5];

`ifdef ENEMY_SHOT_ACCEL_EN
  logic [4:0] alive_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          alive_cnt <= N_ID;
    else if (frame_tick) alive_cnt <= 5'($countones(enemy_alive));
  end

  always_comb begin
    if (alive_cnt < 5'd3)      step = 11'(SPEED + 4);
    else if (alive_cnt < 5'd8) step = 11'(SPEED + 2);
    else                       step = 11'(SPEED);
  end
`else
  assign step = 11'(SPEED);
`endif

  assign pick = (rand_val[4:0] >= N_ID) ? (rand_val[4:0] - N_ID) : rand_val[4:0];

  rect_overlap #(.W(11)) u_ship_hit (
    .a_x     (pos_x),
    .a_y     (pos_y),
    .a_w     (11'(SHOT_W)),
    .a_h     (11'(SHOT_H)),
    .b_x     (posX_Nave),
    .b_y     (11'(SHIP_Y)),
    .b_w     (11'(SHIP_W)),
    .b_h     (11'(SHIP_H)),
    .overlap (overlap)
  );

  assign hit_now = overlap && vivo_jogador;

  always_comb begin
    state_n = state;
    cool_n  = cooldown;
    sel_n   = sel_q;
    att_n   = attempts;
    x_n     = pos_x;
    y_n     = pos_y;
    act_n   = active;
    pend_n  = pend;
    case (state)
      IDLE: begin
        if (frame_tick && vivo_jogador && cooldown != 7'd0) cool_n = cooldown - 7'd1;
        if (cooldown == 7'd0 && vivo_jogador) state_n = SELECT;
      end
      SELECT: begin
        sel_n   = pick;
        att_n   = 5'd0;
        state_n = WAIT;
      end
      WAIT: state_n = CHECK;
      CHECK: begin
        if (enemy_alive[sel_q]) begin
          x_n     = sel_posX + X_OFS_11;
          y_n     = sat_add11(sel_posY, ENEMY_H_11);
          act_n   = 1'b1;
          pend_n  = 1'b0;
          state_n = FLY;
        end else if (attempts == LAST_ID) begin
          cool_n  = COOL_7;
          state_n = IDLE;
        end else begin
          sel_n   = (sel_q == LAST_ID) ? 5'd0 : sel_q + 5'd1;
          att_n   = attempts + 5'd1;
          state_n = WAIT;
        end
      end
      FLY: begin
        // The hit/retire test looks at the position written on the previous tick.
        if (pend) begin
          pend_n = 1'b0;
          if (hit_now) begin
            act_n   = 1'b0;
            state_n = HIT;
          end else if (pos_y >= SCREEN_H_11) begin
            act_n   = 1'b0;
            cool_n  = COOL_7;
            state_n = IDLE;
          end
        end
        if (frame_tick && state_n == FLY) begin
          y_n    = sat_add11(pos_y, step);
          pend_n = 1'b1;
        end
      end
      HIT: begin
        cool_n  = COOL_7;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (!game_run) begin
      state_n = IDLE;
      act_n   = 1'b0;
      pend_n  = 1'b0;
      cool_n  = COOL_7;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cooldown <= COOL_7;
      sel_q    <= 5'd0;
      attempts <= 5'd0;
      pos_x    <= 11'd0;
      pos_y    <= 11'd0;
      active   <= 1'b0;
      pend     <= 1'b0;
    end else begin
      state    <= state_n;
      cooldown <= cool_n;
      sel_q    <= sel_n;
      attempts <= att_n;
      pos_x    <= x_n;
      pos_y    <= y_n;
      active   <= act_n;
      pend     <= pend_n;
    end
  end

  always_comb begin
    h12  = {2'b00, h_counter};
    v12  = {2'b00, v_counter};
    x12  = {1'b0, pos_x};
    y12  = {1'b0, pos_y};
    draw = active &&
           (h12 >= x12) && (h12 < x12 + 12'(SHOT_W)) &&
           (v12 >= y12) && (v12 < y12 + 12'(SHOT_H));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= 8'h00;
      g_q <= 8'h00;
      b_q <= 8'h00;
    end else begin
      r_q <= draw ? SHOT_R : 8'h00;
      g_q <= draw ? SHOT_G : 8'h00;
      b_q <= draw ? SHOT_B : 8'h00;
    end
  end

  assign sel_id             = sel_q;
  assign posX_Municao2      = pos_x;
  assign posY_Municao2      = pos_y;
  assign tiro_ativo_inimigo = active;
  assign hit_jogador        = (state == HIT);
  assign R                  = r_q;
  assign G                  = g_q;
  assign B                  = b_q;
  assign state_dbg          = state;

endmodule

// File: tb/tb_enemy_shot.sv
// Directed bench for enemy_shot: behavioural shot model with a per-cycle
// compare process, plus hand-computed latency/position/colour expectations.
`timescale 1ns/1ps
module tb_enemy_shot;
  import si_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  h_counter, v_counter;
  logic        frame_tick, game_run;
  logic [31:0] rand_val;
  logic [23:0] enemy_alive;
  logic [4:0]  sel_id;
  logic [10:0] sel_posX, sel_posY, posX_Nave;
  logic        vivo_jogador;
  logic [10:0] posX_Municao2, posY_Municao2;
  logic        tiro_ativo_inimigo, hit_jogador;
  logic [7:0]  R, G, B;
  state_t      st_dbg;

  always #5 clk = ~clk;

  enemy_shot dut (
    .clk(clk), .reset(reset), .h_counter(h_counter), .v_counter(v_counter),
    .frame_tick(frame_tick), .game_run(game_run), .rand_val(rand_val),
    .enemy_alive(enemy_alive), .sel_id(sel_id), .sel_posX(sel_posX),
    .sel_posY(sel_posY), .posX_Nave(posX_Nave), .vivo_jogador(vivo_jogador),
    .posX_Municao2(posX_Municao2), .posY_Municao2(posY_Municao2),
    .tiro_ativo_inimigo(tiro_ativo_inimigo), .hit_jogador(hit_jogador),
    .R(R), .G(G), .B(B), .state_dbg(st_dbg)
  );

  // Enemy table lookup answers one clock after sel_id changes.
  logic [10:0] ex [0:23];
  logic [10:0] ey [0:23];
  always @(posedge clk) begin
    sel_posX <= ex[sel_id];
    sel_posY <= ey[sel_id];
  end

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;
  int hit_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Shot model: what the shot must be, from the game rules.
  bit m_active = 0, m_hit = 0, chk_en = 0, prev_chk = 0, p_active = 0;
  int m_x = 0, m_y = 0, p_x = 0, p_y = 0, p_h = 0, p_v = 0;

  always @(negedge clk) begin
    bit on;
    if (hit_jogador) hit_cnt++;
    if (chk_en) begin
      check("m_tiro", tiro_ativo_inimigo, m_active);
      check("m_hit", hit_jogador, m_hit);
      if (m_active) begin
        check("m_posX", posX_Municao2, m_x);
        check("m_posY", posY_Municao2, m_y);
      end
      if (prev_chk) begin
        on = p_active && (p_h >= p_x) && (p_h < p_x + 4) && (p_v >= p_y) && (p_v < p_y + 12);
        check("m_R", R, on ? 32'hFF : 32'h0);
        check("m_G", G, on ? 32'h40 : 32'h0);
        check("m_B", B, 32'h0);
      end
    end
    prev_chk = chk_en;
    p_active = m_active; p_x = m_x; p_y = m_y;
    p_h = int'(h_counter); p_v = int'(v_counter);
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin tick(); cycle(); end
  endtask

  // 59 cooldown ticks must not launch anything; the 60th does.
  task automatic cooldown_then_spawn(input string name, input int exp_n, input int exp_sel,
                                     input int exp_x, input int exp_y, input int idle_sel);
    int n;
    bit got;
    chk_en = 0;
    ticks(59);
    repeat (3) cycle();
    check({name, "_no_early_tiro"}, tiro_ativo_inimigo, 0);
    check({name, "_no_early_state"}, st_dbg, IDLE);
    check({name, "_no_early_sel"}, sel_id, idle_sel);
    tick();
    n = 0; got = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(); n++;
      if (tiro_ativo_inimigo) begin got = 1; break; end
    end
    check({name, "_spawn_latency"}, n, exp_n);
    check({name, "_sel_id"}, sel_id, exp_sel);
    check({name, "_spawn_x"}, posX_Municao2, exp_x);
    check({name, "_spawn_y"}, posY_Municao2, exp_y);
    m_active = got; m_x = exp_x; m_y = exp_y; m_hit = 0;
    chk_en = 1;
  endtask

  task automatic fly_tick();
    int nave;
    tick();
    m_y = (m_y + 4 > 2047) ? 2047 : m_y + 4;
    cycle();
    nave = int'(posX_Nave);
    if (vivo_jogador && (m_x + 4 > nave) && (m_x < nave + 40) && (m_y + 12 > 440) && (m_y < 460)) begin
      m_active = 0; m_hit = 1;
    end else if (m_y >= 480) begin
      m_active = 0;
    end
    cycle();
    m_hit = 0;
  endtask

  task automatic fly_until_done(input string name, input int exp_ticks);
    int k = 0;
    while (m_active && k < 40) begin fly_tick(); k++; end
    check({name, "_flight_ticks"}, k, exp_ticks);
  endtask

  task automatic render(input string name, input int h, input int v, input int exp_r, input int exp_g);
    h_counter = 10'(h); v_counter = 10'(v);
    cycle();
    check({name, "_R"}, R, exp_r);
    check({name, "_G"}, G, exp_g);
    check({name, "_B"}, B, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hits0;
    reset = 1'b0; h_counter = '0; v_counter = '0; frame_tick = 1'b0;
    game_run = 1'b1; vivo_jogador = 1'b1; posX_Nave = 11'd300;
    rand_val = ($urandom() & 32'hFFFF_FFE0) | 32'd27;
    enemy_alive = '1;
    for (int i = 0; i < 24; i++) begin
      ex[i] = 11'(20 + 30 * i);
      ey[i] = 11'(40 + 5 * i);
    end
    ex[3] = 11'd102; ey[3] = 11'd380;
    ex[23] = 11'd192; ey[23] = 11'd210;
    repeat (3) cycle();
    check("rst_tiro", tiro_ativo_inimigo, 0);
    check("rst_hit", hit_jogador, 0);
    check("rst_posX", posX_Municao2, 0);
    check("rst_posY", posY_Municao2, 0);
    check("rst_sel", sel_id, 0);
    check("rst_rgb", {R, G, B}, 0);
    check("rst_state", st_dbg, IDLE);
    reset = 1'b1;

    // All alive, rand 27 -> enemy 3; ship far away so the shot retires at 482.
    cooldown_then_spawn("sel27", 4, 3, 110, 410, 0);
    hits0 = hit_cnt;
    fly_until_done("retire", 18);
    check("retire_posY", posY_Municao2, 482);
    check("retire_no_hit", hit_cnt - hits0, 0);

    // Same spawn, ship under it: hit at y=430 after 5 ticks, one-cycle pulse.
    posX_Nave = 11'd100;
    rand_val = ($urandom() & 32'hFFFF_FFE0) | 32'd3;
    cooldown_then_spawn("hitrun", 4, 3, 110, 410, 3);
    hits0 = hit_cnt;
    fly_until_done("hit", 5);
    check("hit_posY", posY_Municao2, 430);
    check("hit_pulses", hit_cnt - hits0, 1);
    check("hit_tiro", tiro_ativo_inimigo, 0);

    // No live enemy: 24 probes 5..23,0..4, back to IDLE with a fresh cooldown.
    chk_en = 0;
    enemy_alive = '0;
    rand_val = ($urandom() & 32'hFFFF_FFE0) | 32'd5;
    ticks(59);
    tick();
    repeat (49) cycle();
    check("dead_last_probe_state", st_dbg, CHECK);
    check("dead_last_probe_sel", sel_id, 4);
    cycle();
    check("dead_back_idle", st_dbg, IDLE);
    check("dead_no_tiro", tiro_ativo_inimigo, 0);

    // Only enemy 23 alive, rand 20 -> probes 20..23, shot at (200,240).
    enemy_alive = 24'h80_0000;
    rand_val = ($urandom() & 32'hFFFF_FFE0) | 32'd20;
    cooldown_then_spawn("only23", 10, 23, 200, 240, 4);
    render("px_in", 201, 245, 32'hFF, 32'h40);
    render("px_right", 204, 245, 0, 0);
    render("px_corner", 200, 251, 32'hFF, 32'h40);
    render("px_below", 200, 252, 0, 0);
    render("px_left", 199, 240, 0, 0);
    render("px_top", 203, 240, 32'hFF, 32'h40);

    // game_run drop clears the shot without a hit pulse.
    hits0 = hit_cnt;
    game_run = 1'b0;
    cycle();
    m_active = 0;
    cycle();
    check("abort_tiro", tiro_ativo_inimigo, 0);
    check("abort_state", st_dbg, IDLE);
    check("abort_no_hit", hit_cnt - hits0, 0);
    game_run = 1'b1;

    // Reset mid-flight clears outputs before the next clock edge.
    cooldown_then_spawn("prerst", 10, 23, 200, 240, 23);
    fly_tick();
    h_counter = 10'd201; v_counter = 10'd245;
    cycle();
    check("prerst_R", R, 32'hFF);
    chk_en = 0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("async_tiro", tiro_ativo_inimigo, 0);
    check("async_posY", posY_Municao2, 0);
    check("async_rgb", {R, G, B}, 0);
    check("async_state", st_dbg, IDLE);
    m_active = 0;
    cycle(); cycle();
    reset = 1'b1;
    cooldown_then_spawn("postrst", 10, 23, 200, 240, 0);
    cycle();

    chk_en = 0;
    cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
